// File: rtl/axis_nibble_framer_pkg.sv
// Shared definitions for the nibble framer: keep encodings, nibble helpers, FSM states.
package axis_nibble_pkg;

  localparam logic [7:0] KEEP_1N = 8'd4;
  localparam logic [7:0] KEEP_2N = 8'd8;
  localparam logic [7:0] KEEP_3N = 8'd12;
  localparam logic [7:0] KEEP_4N = 8'd16;

  typedef enum logic [2:0] {FILL, DROP, HDR, PAY, TRL} state_t;

  // Any keep value outside the four legal encodings carries no nibbles.
  function automatic logic [2:0] nib_count(input logic [7:0] keep);
    case (keep)
      KEEP_1N: return 3'd1;
      KEEP_2N: return 3'd2;
      KEEP_3N: return 3'd3;
      KEEP_4N: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [15:0] nib_mask(input logic [2:0] n);
    case (n)
      3'd1:    return 16'h000F;
      3'd2:    return 16'h00FF;
      3'd3:    return 16'h0FFF;
      3'd4:    return 16'hFFFF;
      default: return 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/axis_nibble_framer_if.sv
// AXI-stream bus carrying 16-bit packed words with a bit-count keep field.
interface axis_nibble_framer_if;
  logic [15:0] data;
  logic        valid;
  logic        last;
  logic [7:0]  keep;
  logic        ready;

  modport master (output data, valid, last, keep, input ready);
  modport slave  (input data, valid, last, keep, output ready);
endinterface

// File: rtl/axis_nibble_framer_buf.sv
// Packet word store: one write port, one registered read port, {count, data} per entry.
module pkt_word_buf #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [18:0]   wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [18:0]   rd_data
);

  logic [18:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/axis_nibble_framer.sv
// Store-and-forward framer: buffers one packet, then emits header(len), payload, trailer(csum).
module axis_nibble_framer
  import axis_nibble_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  axis_nibble_framer_if.slave  s,
  axis_nibble_framer_if.master m,
  output logic                 pkt_drop
);

  state_t        state_q, state_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [15:0]   len_q, len_d, csum_q, csum_d;
  logic          s_ready_q, drop_d;
  logic          wr_en;
  logic [2:0]    n;
  logic [15:0]   data_z;
  logic [18:0]   rdata;
  logic          full, s_fire;
  logic          m_valid_c, m_last_c;
  logic [15:0]  m_data_c;
  logic [7:0]   m_keep_c;

  assign n      = nib_count(s.keep);
  assign data_z = s.data & nib_mask(n);
  assign s_fire = s.valid && s_ready_q;
  assign full   = (wr_ptr_q == (AW+1)'(DEPTH));

  // Read address follows the next rd_ptr so rdata always holds buffer[rd_ptr_q].
  pkt_word_buf #(.DEPTH(DEPTH), .AW(AW)) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q[AW-1:0]),
    .wr_data ({n, data_z}),
    .rd_addr (rd_ptr_d),
    .rd_data (rdata)
  );

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    len_d     = len_q;
    csum_d    = csum_q;
    wr_en     = 1'b0;
    drop_d    = 1'b0;
    m_valid_c = 1'b0;
    m_last_c  = 1'b0;
    m_data_c  = '0;
    m_keep_c  = '0;
    case (state_q)
      FILL: begin
        if (s_fire) begin
          if (n != 3'd0 && full) begin
            if (s.last) begin
              drop_d   = 1'b1;
              wr_ptr_d = '0;
              rd_ptr_d = '0;
              len_d    = '0;
              csum_d   = '0;
            end else begin
              state_d = DROP;
            end
          end else begin
            if (n != 3'd0) begin
              wr_en    = 1'b1;
              wr_ptr_d = wr_ptr_q + (AW+1)'(1);
              len_d    = len_q + 16'(n);
              csum_d   = csum_q + data_z;
            end
            if (s.last) state_d = HDR;
          end
        end
      end
      DROP: begin
        if (s_fire && s.last) begin
          drop_d   = 1'b1;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          len_d    = '0;
          csum_d   = '0;
          state_d  = FILL;
        end
      end
      HDR: begin
        m_valid_c = 1'b1;
        m_data_c  = len_q;
        m_keep_c  = KEEP_4N;
        if (m.ready) state_d = (wr_ptr_q != '0) ? PAY : TRL;
      end
      PAY: begin
        m_valid_c = 1'b1;
        m_data_c  = rdata[15:0];
        m_keep_c  = {3'b000, rdata[18:16], 2'b00};
        if (m.ready) begin
          rd_ptr_d = rd_ptr_q + AW'(1);
          if ({1'b0, rd_ptr_q} == wr_ptr_q - (AW+1)'(1)) state_d = TRL;
        end
      end
      TRL: begin
        m_valid_c = 1'b1;
        m_data_c  = csum_q;
        m_keep_c  = KEEP_4N;
        m_last_c  = 1'b1;
        if (m.ready) begin
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          len_d    = '0;
          csum_d   = '0;
          state_d  = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FILL;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      len_q     <= '0;
      csum_q    <= '0;
      s_ready_q <= 1'b0;
      pkt_drop  <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      len_q     <= len_d;
      csum_q    <= csum_d;
      s_ready_q <= (state_d == FILL) || (state_d == DROP);
      pkt_drop  <= drop_d;
    end
  end

  assign s.ready = s_ready_q;
  assign m.valid = m_valid_c;
  assign m.data  = m_data_c;
  assign m.keep  = m_keep_c;
  assign m.last  = m_last_c;

endmodule

// File: tb/tb_axis_nibble_framer.sv
// Directed bench for axis_nibble_framer with a packet-level reference model.
module tb_axis_nibble_framer;

  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  logic pkt_drop;

  axis_nibble_framer_if s_if ();
  axis_nibble_framer_if m_if ();

  axis_nibble_framer #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .s        (s_if),
    .m        (m_if),
    .pkt_drop (pkt_drop)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Beats are packed as {last, keep[7:0], data[15:0]}.
  logic [24:0] exp_q [$];
  logic [24:0] got   [$];
  logic [24:0] lit   [$];
  logic [24:0] mwords [$];
  logic [15:0] mlen, msum;
  int          mcnt;
  bit          movf;
  bit          drop_pending;
  int          drop_cnt;
  bit          prev_stall;
  logic [24:0] prev_beat;
  bit          bp;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [24:0] beat(input logic [15:0] d, input logic [7:0] k, input logic l);
    return {l, k, d};
  endfunction

  task automatic model_clear();
    mwords.delete();
    mlen = '0;
    msum = '0;
    mcnt = 0;
    movf = 0;
  endtask

  task automatic model_accept(input logic [15:0] d, input logic [7:0] k, input logic l);
    int n;
    logic [15:0] dz;
    n  = (k == 8'd4) ? 1 : (k == 8'd8) ? 2 : (k == 8'd12) ? 3 : (k == 8'd16) ? 4 : 0;
    dz = (n == 4) ? d : (d & ((16'h1 << (4 * n)) - 16'h1));
    if (n > 0) begin
      if (mcnt == int'(DEPTH)) movf = 1;
      else if (!movf) begin
        mwords.push_back(beat(dz, 8'(4 * n), 1'b0));
        mcnt++;
      end
      mlen = mlen + 16'(n);
      msum = msum + dz;
    end
    if (l) begin
      if (movf) drop_pending = 1;
      else begin
        exp_q.push_back(beat(mlen, 8'd16, 1'b0));
        foreach (mwords[i]) exp_q.push_back(mwords[i]);
        exp_q.push_back(beat(msum, 8'd16, 1'b1));
      end
      model_clear();
    end
  endtask

  // Compare process: evaluates the handshake that the next rising edge will complete.
  initial begin
    model_clear();
    drop_pending = 0;
    drop_cnt = 0;
    prev_stall = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        model_clear();
        drop_pending = 0;
        prev_stall = 0;
      end else begin
        if (prev_stall)
          chk("hold", {6'd0, m_if.valid, m_if.last, m_if.keep, m_if.data}, {6'd0, 1'b1, prev_beat});
        if (m_if.valid) chk("s_ready_in_output", 32'(s_if.ready), 32'd0);
        chk("pkt_drop", 32'(pkt_drop), 32'(drop_pending));
        if (pkt_drop) drop_cnt++;
        drop_pending = 0;
        if (m_if.valid && m_if.ready) begin
          got.push_back(beat(m_if.data, m_if.keep, m_if.last));
          if (exp_q.size() == 0) chk("unexpected_beat", 32'(m_if.data), 32'hxxxx_xxxx);
          else chk("out_beat", 32'(beat(m_if.data, m_if.keep, m_if.last)), 32'(exp_q.pop_front()));
        end
        prev_stall = m_if.valid && !m_if.ready;
        prev_beat  = beat(m_if.data, m_if.keep, m_if.last);
        if (s_if.valid && s_if.ready) model_accept(s_if.data, s_if.keep, s_if.last);
      end
    end
  end

  // Downstream ready: always 1, or the repeating pattern 1,0,0 under backpressure.
  initial begin
    int ph = 0;
    m_if.ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp) begin
        m_if.ready = (ph == 0);
        ph = (ph + 1) % 3;
      end else begin
        m_if.ready = 1'b1;
        ph = 0;
      end
    end
  end

  task automatic send(input logic [15:0] d, input logic [7:0] k, input logic l);
    bit acc = 0;
    s_if.data  = d;
    s_if.keep  = k;
    s_if.last  = l;
    s_if.valid = 1'b1;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = s_if.ready;
      @(posedge clk);
      #1;
    end
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
    s_if.valid = 1'b0;
    s_if.last  = 1'b0;
  endtask

  task automatic wait_done();
    bit done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !m_if.valid) done = 1;
    end
    if (!done) chk("drain_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic expect_beats(input string nm);
    chk({nm, "_count"}, 32'(got.size()), 32'(lit.size()));
    for (int i = 0; i < lit.size(); i++)
      if (i < got.size()) chk(nm, 32'(got[i]), 32'(lit[i]));
    got.delete();
    lit.delete();
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_m_valid",  32'(m_if.valid), 32'd0);
    chk("rst_m_data",   32'(m_if.data),  32'd0);
    chk("rst_m_last",   32'(m_if.last),  32'd0);
    chk("rst_m_keep",   32'(m_if.keep),  32'd0);
    chk("rst_s_ready",  32'(s_if.ready), 32'd0);
    chk("rst_pkt_drop", 32'(pkt_drop),   32'd0);
    @(negedge clk);
    chk("s_ready_rise", 32'(s_if.ready), 32'd1);
    @(posedge clk);
    #1;
    got.delete();
  endtask

  initial begin
    bp = 0;
    rst = 1'b1;
    s_if.valid = 1'b0;
    s_if.data  = '0;
    s_if.keep  = '0;
    s_if.last  = 1'b0;
    do_reset(3);

    // Basic three-word packet, header visible one cycle after the last beat.
    send(16'h1234, 8'd16, 1'b0);
    send(16'h5678, 8'd16, 1'b0);
    send(16'h000A, 8'd4,  1'b1);
    @(negedge clk);
    chk("hdr_latency_valid", 32'(m_if.valid), 32'd1);
    chk("hdr_latency_data",  32'(m_if.data),  32'h0009);
    wait_done();
    lit = '{beat(16'h0009, 8'd16, 1'b0), beat(16'h1234, 8'd16, 1'b0), beat(16'h5678, 8'd16, 1'b0),
            beat(16'h000A, 8'd4, 1'b0), beat(16'h68B6, 8'd16, 1'b1)};
    expect_beats("pkt1");

    // Upper nibbles beyond keep are zeroed.
    send(16'hFFFF, 8'd8, 1'b1);
    wait_done();
    lit = '{beat(16'h0002, 8'd16, 1'b0), beat(16'h00FF, 8'd8, 1'b0), beat(16'h00FF, 8'd16, 1'b1)};
    expect_beats("mask");

    // Zero-nibble packet.
    send(16'hABCD, 8'd0, 1'b1);
    wait_done();
    lit = '{beat(16'h0000, 8'd16, 1'b0), beat(16'h0000, 8'd16, 1'b1)};
    expect_beats("zero");

    // Backpressure with ready pattern 1,0,0.
    bp = 1;
    send(16'h1111, 8'd16, 1'b0);
    send(16'h2222, 8'd12, 1'b0);
    send(16'hAB33, 8'd8,  1'b1);
    wait_done();
    bp = 0;
    lit = '{beat(16'h0009, 8'd16, 1'b0), beat(16'h1111, 8'd16, 1'b0), beat(16'h0222, 8'd12, 1'b0),
            beat(16'h0033, 8'd8, 1'b0), beat(16'h1366, 8'd16, 1'b1)};
    expect_beats("bp");

    // Overflow: six full beats plus a last beat into a 4-word buffer.
    drop_cnt = 0;
    for (int i = 0; i < 6; i++) send(16'(16'h0100 + i), 8'd16, 1'b0);
    send(16'h0F00, 8'd16, 1'b1);
    repeat (4) @(negedge clk);
    chk("drop_pulses", 32'(drop_cnt), 32'd1);
    chk("drop_no_output", 32'(got.size()), 32'd0);
    @(posedge clk);
    #1;
    send(16'h0001, 8'd4, 1'b1);
    wait_done();
    lit = '{beat(16'h0001, 8'd16, 1'b0), beat(16'h0001, 8'd4, 1'b0), beat(16'h0001, 8'd16, 1'b1)};
    expect_beats("after_drop");

    // Reset while the payload is being emitted.
    send(16'h1234, 8'd16, 1'b0);
    send(16'h5678, 8'd16, 1'b0);
    send(16'h000A, 8'd4,  1'b1);
    @(posedge clk);
    #1;
    do_reset(1);
    send(16'h0F0F, 8'd16, 1'b1);
    wait_done();
    lit = '{beat(16'h0004, 8'd16, 1'b0), beat(16'h0F0F, 8'd16, 1'b0), beat(16'h0F0F, 8'd16, 1'b1)};
    expect_beats("after_rst");

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

endmodule
